// File: rtl/msg_serializer_if.sv
// Message-in / beat-out handshake bundle for msg_serializer.
// Signal names follow the method-to-pipe packer's naming.
interface msg_serializer_if;
    logic         in_enq__ENA;
    logic [127:0] in_enq_v;
    logic         in_enq__RDY;
    logic         out_enq__ENA;
    logic [31:0]  out_enq_v;
    logic         out_enq_last;
    logic         out_enq__RDY;

    modport slave (
        input  in_enq__ENA,
        input  in_enq_v,
        input  out_enq__RDY,
        output in_enq__RDY,
        output out_enq__ENA,
        output out_enq_v,
        output out_enq_last
    );

    modport master (
        output in_enq__ENA,
        output in_enq_v,
        output out_enq__RDY,
        input  in_enq__RDY,
        input  out_enq__ENA,
        input  out_enq_v,
        input  out_enq_last
    );
endinterface

// File: rtl/msg_serializer.sv
// Buffers 128-bit pipe messages and emits them as 32-bit beats,
// low word first; illegal word counts are dropped and counted.
module msg_serializer #(
    parameter int DEPTH  = 2,
    parameter int MAXLEN = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    msg_serializer_if.slave   bus,
    output logic [31:0]       msg_count,
    output logic [15:0]       drop_count,
    output logic              err_len
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [15:0]   MAXL = 16'(MAXLEN);

    typedef enum logic { IDLE, SEND } state_t;

    logic [127:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q, state_d;
    logic [127:0]  shift_q, shift_d;
    logic [15:0]   remain_q, remain_d;
    logic [31:0]   msg_q, msg_d;
    logic [15:0]   drop_q, drop_d;
    logic          err_q, err_d;

    logic          enq, pop, empty;
    logic [127:0]  head;
    logic [15:0]   head_len;
    logic          head_ok;

    assign enq      = bus.in_enq__ENA && (count_q != FULL);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign head_len = head[15:0];
    // Full 16-bit compare so large counts are never aliased into range.
    assign head_ok  = (head_len != 16'd0) && (head_len <= MAXL);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        remain_d = remain_q;
        msg_d    = msg_q;
        drop_d   = drop_q;
        err_d    = err_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        shift_d  = head;
                        remain_d = head_len;
                        state_d  = SEND;
                    end else begin
                        if (drop_q != 16'hFFFF)
                            drop_d = drop_q + 16'd1;
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (bus.out_enq__RDY) begin
                    if (remain_q > 16'd1) begin
                        shift_d  = shift_q >> 32;
                        remain_d = remain_q - 16'd1;
                    end else begin
                        msg_d = msg_q + 32'd1;
                        // Chain straight into a legal head: no bubble.
                        if (!empty && head_ok) begin
                            pop      = 1'b1;
                            shift_d  = head;
                            remain_d = head_len;
                        end else begin
                            state_d  = IDLE;
                            shift_d  = '0;
                            remain_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (enq && !pop)
            count_d = count_q + CW'(1);
        else if (!enq && pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (enq)
            mem_q[wr_ptr_q] <= bus.in_enq_v;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            shift_q  <= '0;
            remain_q <= '0;
            msg_q    <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (enq)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            state_q  <= state_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
            msg_q    <= msg_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_enq__RDY  = (count_q != FULL);
    assign bus.out_enq__ENA = (state_q == SEND) && bus.out_enq__RDY;
    assign bus.out_enq_v    = shift_q[31:0];
    assign bus.out_enq_last = (state_q == SEND) && (remain_q == 16'd1);

    assign msg_count  = msg_q;
    assign drop_count = drop_q;
    assign err_len    = err_q;
endmodule
